fp_norm_pipe: RTL and testbench

Parametrised, two-stage pipelined normaliser for the FP adder datapath. Takes the raw adder mantissa with its carry-out and the pre-normalisation exponent. Performs a single right shift on carry-out, or a full leading-zero left normalisation clamped at the denormal boundary. Returns normalised mantissa, adjusted exponent and status flags to the rounding stage over a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 9 +
 rtl/fp_norm_pipe_if.sv | 26 ++
 rtl/fp_lzc.sv | 23 ++
 rtl/fp_norm_pipe.sv | 87 ++++++++
 tb/tb_fp_norm_pipe.sv | 127 ++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP datapath types, default widths and exponent helper
package fpu_pkg;
  typedef enum logic [1:0] {NORM_PASS, NORM_RIGHT, NORM_LEFT, NORM_ZERO} norm_case_e;
  localparam int MANT_W_DEF = 27;
  localparam int EXP_W_DEF = 8;
  function automatic int exp_all_ones(int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/fp_norm_pipe_if.sv
// fp_norm_pipe_if: input beat and output result handshake bundle of the normaliser
interface fp_norm_pipe_if import fpu_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
);
  logic in_valid;
  logic in_ready;
  logic [MANT_W-1:0] in_mant;
  logic in_ovf;
  logic [EXP_W-1:0] in_exp;
  logic out_valid;
  logic out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic out_zero;
  logic out_uflow;
  logic out_oflow;
  modport master (
    output in_valid, in_mant, in_ovf, in_exp, out_ready,
    input in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, out_oflow
  );
  modport slave (
    input in_valid, in_mant, in_ovf, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow, out_oflow
  );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: binary-tree leading-zero counter, returns MANT_W for an all-zero input
module fp_lzc #(
  parameter int MANT_W = 27,
  localparam int LZ_W = $clog2(MANT_W + 1)
) (
  input  logic [MANT_W-1:0] mant,
  output logic [LZ_W-1:0]   lz
);
  localparam int H = MANT_W - MANT_W / 2;
  localparam int LW = MANT_W / 2;
  if (MANT_W == 1) begin : g_leaf
    assign lz = !mant[0];
  end else begin : g_node
    localparam int HZ = $clog2(H + 1);
    localparam int LZ = $clog2(LW + 1);
    logic [HZ-1:0] lz_hi;
    logic [LZ-1:0] lz_lo;
    fp_lzc #(.MANT_W(H)) u_hi (.mant(mant[MANT_W-1 -: H]), .lz(lz_hi));
    fp_lzc #(.MANT_W(LW)) u_lo (.mant(mant[LW-1:0]), .lz(lz_lo));
    // an all-zero upper half means the count continues into the lower half
    assign lz = (lz_hi == HZ'(H)) ? LZ_W'(H) + LZ_W'(lz_lo) : LZ_W'(lz_hi);
  end
endmodule

// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage post-add normaliser (carry right shift / clamped left normalise)
module fp_norm_pipe import fpu_pkg::*; #(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  localparam int LZ_W = $clog2(MANT_W + 1)
) (
  input logic clk,
  input logic rst,
  fp_norm_pipe_if.slave bus
);
  localparam logic [EXP_W:0] EMAX = (EXP_W + 1)'(exp_all_ones(EXP_W));
  logic s1_valid, s1_ovf, s1_en, s2_en;
  logic [MANT_W-1:0] s1_mant, n_mant;
  logic [EXP_W-1:0] s1_exp, n_exp, l_exp;
  logic [LZ_W-1:0] s1_lz, lz;
  logic [EXP_W:0] e1, lz_e, r_exp, l_sh;
  logic l_ok, n_zero, n_uflow, n_oflow;
  norm_case_e ncase;
  assign s2_en = !bus.out_valid || bus.out_ready;
  assign s1_en = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;
  fp_lzc #(.MANT_W(MANT_W)) u_lzc (.mant(bus.in_mant), .lz(lz));
  // stage 1 occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= bus.in_valid;
  // stage 1 data capture, leading-zero count computed on the way in
  always_ff @(posedge clk)
    if (s1_en && bus.in_valid) begin
      s1_mant <= bus.in_mant;
      s1_ovf <= bus.in_ovf;
      s1_exp <= bus.in_exp;
      s1_lz <= lz;
    end
  // stage 2 case selection, shift and exponent adjust at EXP_W+1 bits so nothing wraps
  always_comb begin
    ncase = s1_ovf ? NORM_RIGHT : s1_mant[MANT_W-1] ? NORM_PASS : (s1_lz == LZ_W'(MANT_W)) ? NORM_ZERO : NORM_LEFT;
    e1 = {1'b0, s1_exp};
    lz_e = (EXP_W + 1)'(s1_lz);
    r_exp = e1 + (EXP_W + 1)'(1);
    l_ok = e1 > lz_e;
    l_exp = s1_exp - lz_e[EXP_W-1:0];
    l_sh = l_ok ? lz_e : (e1 == '0) ? '0 : e1 - (EXP_W + 1)'(1);
    n_mant = s1_mant;
    n_exp = s1_exp;
    n_zero = 1'b0;
    n_uflow = 1'b0;
    n_oflow = 1'b0;
    case (ncase)
      NORM_RIGHT: begin
        n_oflow = r_exp >= EMAX;
        n_mant = n_oflow ? '0 : {1'b1, s1_mant[MANT_W-1:2], |s1_mant[1:0]};
        n_exp = n_oflow ? EMAX[EXP_W-1:0] : r_exp[EXP_W-1:0];
      end
      NORM_LEFT: begin
        n_uflow = !l_ok;
        n_mant = s1_mant << l_sh;
        n_exp = l_ok ? l_exp : '0;
      end
      NORM_ZERO: begin
        n_mant = '0;
        n_exp = '0;
        n_zero = 1'b1;
      end
      default: ;
    endcase
  end
  // output register; holds while the consumer stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_mant <= '0;
      bus.out_exp <= '0;
      bus.out_zero <= 1'b0;
      bus.out_uflow <= 1'b0;
      bus.out_oflow <= 1'b0;
    end else if (s2_en) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_mant <= n_mant;
        bus.out_exp <= n_exp;
        bus.out_zero <= n_zero;
        bus.out_uflow <= n_uflow;
        bus.out_oflow <= n_oflow;
      end
    end
endmodule

// File: tb/tb_fp_norm_pipe.sv
// tb_fp_norm_pipe: directed vectors, backpressure and async reset checks for fp_norm_pipe
module tb_fp_norm_pipe;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fp_norm_pipe_if #(.MANT_W(27), .EXP_W(8)) bus ();
  fp_norm_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, ".valid"}, bus.out_valid, 0);
    check({tag, ".mant"}, bus.out_mant, 0);
    check({tag, ".exp"}, bus.out_exp, 0);
    check({tag, ".flags"}, {bus.out_zero, bus.out_uflow, bus.out_oflow}, 0);
    check({tag, ".in_ready"}, bus.in_ready, 1);
  endtask
  // flags argument is {zero, uflow, oflow}
  task automatic run_vec(input string tag, input logic [26:0] m, input logic ovf, input logic [7:0] e,
                         input logic [26:0] em, input logic [7:0] ee, input logic [2:0] ef);
    int n;
    @(negedge clk);
    check({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_mant = m;
    bus.in_ovf = ovf;
    bus.in_exp = e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, 1);
    check({tag, ".mant"}, bus.out_mant, em);
    check({tag, ".exp"}, bus.out_exp, ee);
    check({tag, ".flags"}, {bus.out_zero, bus.out_uflow, bus.out_oflow}, ef);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int sent, rcv, cyc, stale;
    logic [26:0] held;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mant = '0;
    bus.in_ovf = 1'b0;
    bus.in_exp = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    run_vec("pass", 27'h4000000, 1'b0, 8'd100, 27'h4000000, 8'd100, 3'b000);
    run_vec("right", 27'h0000003, 1'b1, 8'd100, 27'h4000001, 8'd101, 3'b000);
    run_vec("right_full", 27'h7ffffff, 1'b1, 8'd10, 27'h7ffffff, 8'd11, 3'b000);
    run_vec("oflow", 27'h0000003, 1'b1, 8'd254, 27'h0000000, 8'd255, 3'b001);
    run_vec("left", 27'h0000100, 1'b0, 8'd100, 27'h4000000, 8'd82, 3'b000);
    run_vec("left_lsb", 27'h0000001, 1'b0, 8'd30, 27'h4000000, 8'd4, 3'b000);
    run_vec("uflow_eq", 27'h0000001, 1'b0, 8'd26, 27'h2000000, 8'd0, 3'b010);
    run_vec("uflow5", 27'h0000100, 1'b0, 8'd5, 27'h0001000, 8'd0, 3'b010);
    run_vec("uflow0", 27'h0000100, 1'b0, 8'd0, 27'h0000100, 8'd0, 3'b010);
    run_vec("zero", 27'h0000000, 1'b0, 8'd77, 27'h0000000, 8'd0, 3'b100);
    sent = 0;
    rcv = 0;
    cyc = 0;
    held = '0;
    while (rcv < 5 && cyc < 40) begin
      @(negedge clk);
      bus.out_ready = cyc >= 6;
      bus.in_valid = sent < 5;
      bus.in_mant = 27'h4000000 | 27'(sent);
      bus.in_ovf = 1'b0;
      bus.in_exp = 8'(10 + sent);
      #1;
      if (cyc == 2) begin
        check("bp.in_ready", bus.in_ready, 0);
        check("bp.accepted", sent, 2);
        held = bus.out_mant;
      end
      if (cyc == 5) begin
        check("bp.hold_valid", bus.out_valid, 1);
        check("bp.hold_mant", bus.out_mant, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("bp.mant", bus.out_mant, 27'h4000000 | 27'(rcv));
        check("bp.exp", bus.out_exp, 8'(10 + rcv));
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("bp.delivered", rcv, 5);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mant = 27'h4000005;
    bus.in_exp = 8'd9;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst.pre_full", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1 check_idle("rst.async");
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("rst.stale", stale, 0);
    run_vec("post_rst", 27'h0000100, 1'b0, 8'd100, 27'h4000000, 8'd82, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
